// File: rtl/fifo_stream_reader.sv
// Read-side master for the fifo: credit-limited read strobes, in-flight tracking across the
// fifo read latency, and an ordered output buffer presented as a valid/ready stream.
module fifo_stream_reader #(
  parameter int DW         = 24,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic          o_fifo_rd,
  input  logic [DW-1:0] i_fifo_rdata,
  input  logic          i_fifo_empty,
  output logic [DW-1:0] o_tdata,
  output logic          o_tvalid,
  input  logic          i_tready,
  output logic          o_busy
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int OW = CW + 1;

  logic [RD_LATENCY-1:0] infl_vld;
  logic [RD_LATENCY-1:0] infl_vld_next;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic [OW-1:0]         occupancy;
  logic [OW-1:0]         occupancy_next;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  capture;
  logic                  handshake;
  logic [DW-1:0]         mem [BUF_DEPTH];

  function automatic logic [OW-1:0] ones(input logic [RD_LATENCY-1:0] v);
    logic [OW-1:0] n;
    n = '0;
    for (int i = 0; i < RD_LATENCY; i++) n = n + OW'(v[i]);
    return n;
  endfunction

  // Credit check counts words already in flight so the buffer can never overflow.
  always_comb begin
    occupancy     = OW'(count) + ones(infl_vld);
    o_fifo_rd     = !rst && i_en && !i_fifo_empty && (occupancy < OW'(BUF_DEPTH));
    capture       = infl_vld[RD_LATENCY-1];
    handshake     = o_tvalid && i_tready;
    infl_vld_next = (infl_vld << 1) | RD_LATENCY'(o_fifo_rd);
    count_next    = count;
    case ({capture, handshake})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
    occupancy_next = OW'(count_next) + ones(infl_vld_next);
  end

  // Control state: in-flight shift register, pointers, count and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      infl_vld <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_tvalid <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      infl_vld <= infl_vld_next;
      count    <= count_next;
      if (capture)   wr_ptr <= wr_ptr + AW'(1);
      if (handshake) rd_ptr <= rd_ptr + AW'(1);
      o_tvalid <= (count_next != '0);
      o_busy   <= (occupancy_next != '0);
    end
  end

  // Data capture: the slot at wr_ptr is free whenever a word lands, so no reset is needed.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= i_fifo_rdata;
  end

  assign o_tdata = o_tvalid ? mem[rd_ptr] : '0;

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side master for the team's `fifo` block.
- Issues read strobes into the fifo's read port and tracks words in flight across the fifo's registered read latency.
- Lands each returned word in a small ordered output buffer and presents it as a valid/ready stream to downstream DSP.
- Throughput is 1 word/cycle when downstream is ready and the fifo is non-empty; no loss, duplication or reordering.

Parameters:
- DW, 24: data width in bits; must match the fifo.
- RD_LATENCY, 1: cycles from a strobe on `o_fifo_rd` until that word is valid on `i_fifo_rdata`; range 1..4.
- BUF_DEPTH, 4: output buffer entries; power of 2; must be >= RD_LATENCY+2 for full throughput.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- i_en  in  1  enables issuing new fifo reads.
- o_fifo_rd  out  1  read strobe to the fifo.
- i_fifo_rdata  in  DW  fifo read data.
- i_fifo_empty  in  1  fifo empty / almost-empty flag.
- o_tdata  out  DW  stream data.
- o_tvalid  out  1  stream valid.
- i_tready  in  1  stream ready.
- o_busy  out  1  high while any word is in flight or buffered.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports `clk`, `rst`).
- Reset values: `o_fifo_rd`=0 (forced low combinationally while `rst`=1), `o_tvalid`=0, `o_tdata`=0, `o_busy`=0.
  - Reset clears buffer write/read pointers, buffer count and the in-flight shift register.
- Definitions:
  - inflight = number of set bits in a RD_LATENCY-stage shift register; a strobe enters at stage 0.
  - occupancy = buffered count + inflight.
- Read strobe: `o_fifo_rd` = `!rst && i_en && !i_fifo_empty && occupancy < BUF_DEPTH`.
  - No combinational dependence on `i_tready`.
  - At most one strobe per cycle.
- Capture: when the shift register's last stage is set, `i_fifo_rdata` is written into the buffer at the write pointer at that clock edge.
  - Write pointer increments, wrapping modulo BUF_DEPTH.
- Latency: strobe in cycle t, data on `i_fifo_rdata` in cycle t+RD_LATENCY, `o_tvalid`=1 from cycle t+RD_LATENCY+1. No bypass path.
- Stream output:
  - `o_tvalid` = (count != 0), registered.
  - `o_tdata` = buffer[read pointer].
  - Handshake occurs when `o_tvalid && i_tready`; the read pointer then advances and wraps.
  - While `o_tvalid`=1 and `i_tready`=0, `o_tdata` and `o_tvalid` hold stable.
  - `o_tdata` content is not checked while `o_tvalid`=0.
- Count update:
  - +1 on capture, -1 on handshake, unchanged when both occur in the same cycle.
  - Width is clog2(BUF_DEPTH)+1 bits.
- Overflow is impossible by construction, because strobes are credit-limited by occupancy. Bench asserts count <= BUF_DEPTH every cycle.
- Empty flag: `i_fifo_empty` must be registered and conservative; connect the fifo's almost-empty (`ALMOST_EMPTY`=1). A strobe issued while the fifo is truly empty is a system error, not handled here.
- `i_en` deassert: stops new strobes the same cycle. In-flight words still land and drain normally.
- `o_busy` = (occupancy != 0), registered; it falls the cycle after the last handshake once nothing is in flight.
- Reset mid-operation: in-flight and buffered words are discarded. The fifo's read pointer has already advanced, so those words are lost upstream by design.

Test Plan:
- Word stream: after reset, `i_en`=1, `i_fifo_empty`=0, fifo model returning 1,2,3,... with 1-cycle latency, `i_tready`=1 -> `o_fifo_rd` high from cycle 0, first `o_tvalid` in cycle 2 with `o_tdata`=1, then 2,3,4,... one per cycle with no gaps.
- Backpressure: `i_tready` held 0 for 6 cycles mid-stream -> `o_fifo_rd` drops once occupancy=4, `o_tdata` stable throughout; after release the sequence continues with no skipped or duplicated value.
- Enable drop: `i_en` dropped with 1 in flight and 2 buffered -> no further strobes, 3 remaining words delivered in order, `o_busy`=0 one cycle after the last handshake.
- Empty gating: `i_fifo_empty`=1 -> `o_fifo_rd` stays 0. Deassert at cycle k -> strobe at cycle k, `o_tvalid` at k+2.
- Reset mid-stream: `rst` pulsed with 3 words buffered -> next cycle `o_tvalid`=0, `o_busy`=0, `o_fifo_rd`=0; after release the stream resumes from the fifo's next word.
- Latency variant: RD_LATENCY=2, BUF_DEPTH=4, random `i_tready` (50%) over 1000 words -> output order equals fifo order, occupancy never exceeds 4, and throughput is 1/cycle whenever `i_tready`=1 is sustained.
